drone_jogo_param: RTL

- Parametrised game core for the drone simulator: grid of LARG columns by ALT rows, a configurable number of lives, a per-move timeout scaled by a mode input, and collision rollback.
- Replaces the fixed-size datapath/control pair with a single generic engine.
- Reads obstacles from an external column-map ROM that it addresses with its own horizontal position.
- Display and 7-segment decoding stay outside this block.

---
 rtl/drone_pkg.sv | 24 ++
 rtl/edge_detector.sv | 18 +
 rtl/drone_jogo_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/drone_pkg.sv
// rtl/drone_pkg.sv - shared state, control and mode codes for the drone game core
package drone_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL  = 4'd0,
    ST_PREPARA  = 4'd1,
    ST_ESPERA   = 4'd2,
    ST_MOVE     = 4'd3,
    ST_CHECA    = 4'd4,
    ST_ATUALIZA = 4'd5,
    ST_VENCEU   = 4'd6,
    ST_PERDEU   = 4'd7
  } estado_t;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_POS  = 2'b01;
  localparam logic [1:0] CTRL_NEG  = 2'b10;

  localparam logic [1:0] MODO_CHEIO  = 2'b00;
  localparam logic [1:0] MODO_METADE = 2'b01;
  localparam logic [1:0] MODO_QUARTO = 2'b10;
  localparam logic [1:0] MODO_LIVRE  = 2'b11;

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - rising-edge detector with synchronous active-high reset
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic historico;

  always_ff @(posedge clock) begin
    if (reset) historico <= 1'b0;
    else       historico <= sinal;
  end

  assign pulso = sinal & ~historico;

endmodule

// File: rtl/drone_jogo_param.sv
// rtl/drone_jogo_param.sv - parametrised drone game engine with lives, move timeout and collision rollback
// Optional once-per-game bonus life when DRONE_VIDA_EXTRA_EN is defined.
module drone_jogo_param
  import drone_pkg::*;
#(
  parameter int LARG      = 16,
  parameter int ALT       = 8,
  parameter int VIDAS_MAX = 3,
  parameter int T_JOGADA  = 1000,
  parameter int W_COL     = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           iniciar,
  input  logic                           confirma,
  input  logic [1:0]                     controle_vertical,
  input  logic [1:0]                     controle_horizontal,
  input  logic [1:0]                     modo,
  input  logic [ALT-1:0]                 mapa_coluna,
  output logic [$clog2(LARG)-1:0]        posicao_horizontal,
  output logic [$clog2(ALT)-1:0]         posicao_vertical,
  output logic [$clog2(VIDAS_MAX+1)-1:0] vidas,
  output logic [W_COL-1:0]               colisoes,
  output logic                           colisao,
  output logic                           venceu,
  output logic                           perdeu,
  output logic                           timeout,
  output logic [3:0]                     db_estado
);

  localparam int WH   = $clog2(LARG);
  localparam int WV   = $clog2(ALT);
  localparam int WVID = $clog2(VIDAS_MAX + 1);
  localparam int WT   = $clog2(T_JOGADA + 1);

  localparam logic [WH-1:0]   H_MAX   = WH'(LARG - 1);
  localparam logic [WV-1:0]   V_MAX   = WV'(ALT - 1);
  localparam logic [WV-1:0]   V_MEIO  = WV'(ALT / 2);
  localparam logic [WVID-1:0] VID_INI = WVID'(VIDAS_MAX);
  localparam logic [WT-1:0]   LIM0_M1 = WT'(T_JOGADA - 1);
  localparam logic [WT-1:0]   LIM1_M1 = WT'(T_JOGADA / 2 - 1);
  localparam logic [WT-1:0]   LIM2_M1 = WT'(T_JOGADA / 4 - 1);

  estado_t       estado;
  logic [1:0]    modo_reg;
  logic [WT-1:0] timer;
  logic [WT-1:0] limite_m1;
  logic [WH-1:0] h_ant, h_nxt;
  logic [WV-1:0] v_ant, v_nxt;
  logic          confirma_pulso;
  logic          bate;
`ifdef DRONE_VIDA_EXTRA_EN
  localparam logic [WH-1:0] H_MEIO = WH'(LARG / 2);
  logic          bonus_dado;
`endif

  edge_detector u_edge_confirma (
    .clock (clock),
    .reset (reset),
    .sinal (confirma),
    .pulso (confirma_pulso)
  );

  always_comb begin
    limite_m1 = LIM0_M1;
    case (modo_reg)
      MODO_METADE: limite_m1 = LIM1_M1;
      MODO_QUARTO: limite_m1 = LIM2_M1;
      default:     limite_m1 = LIM0_M1;
    endcase
  end

  // Saturating next position; codes 00/11 both hold.
  always_comb begin
    h_nxt = posicao_horizontal;
    if (controle_horizontal == CTRL_POS && posicao_horizontal != H_MAX)
      h_nxt = posicao_horizontal + 1'b1;
    else if (controle_horizontal == CTRL_NEG && posicao_horizontal != '0)
      h_nxt = posicao_horizontal - 1'b1;
    v_nxt = posicao_vertical;
    if (controle_vertical == CTRL_POS && posicao_vertical != V_MAX)
      v_nxt = posicao_vertical + 1'b1;
    else if (controle_vertical == CTRL_NEG && posicao_vertical != '0)
      v_nxt = posicao_vertical - 1'b1;
  end

  assign bate      = mapa_coluna[posicao_vertical];
  assign colisao   = (estado == ST_CHECA) && bate;
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado             <= ST_INICIAL;
      modo_reg           <= MODO_CHEIO;
      timer              <= '0;
      posicao_horizontal <= '0;
      posicao_vertical   <= V_MEIO;
      h_ant              <= '0;
      v_ant              <= V_MEIO;
      vidas              <= VID_INI;
      colisoes           <= '0;
      venceu             <= 1'b0;
      perdeu             <= 1'b0;
      timeout            <= 1'b0;
`ifdef DRONE_VIDA_EXTRA_EN
      bonus_dado         <= 1'b0;
`endif
    end else begin
      case (estado)
        ST_INICIAL: if (iniciar) estado <= ST_PREPARA;
        ST_PREPARA: begin
          posicao_horizontal <= '0;
          posicao_vertical   <= V_MEIO;
          vidas              <= VID_INI;
          colisoes           <= '0;
          timer              <= '0;
          venceu             <= 1'b0;
          perdeu             <= 1'b0;
          timeout            <= 1'b0;
          modo_reg           <= modo;
`ifdef DRONE_VIDA_EXTRA_EN
          bonus_dado         <= 1'b0;
`endif
          estado             <= ST_ESPERA;
        end
        ST_ESPERA: begin
          // Expiry is checked before the confirma edge so a tie ends the game.
          if (modo_reg != MODO_LIVRE && timer == limite_m1) begin
            perdeu  <= 1'b1;
            timeout <= 1'b1;
            estado  <= ST_PERDEU;
          end else begin
            if (modo_reg != MODO_LIVRE) timer <= timer + 1'b1;
            if (confirma_pulso) estado <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          h_ant              <= posicao_horizontal;
          v_ant              <= posicao_vertical;
          posicao_horizontal <= h_nxt;
          posicao_vertical   <= v_nxt;
          estado             <= ST_CHECA;
        end
        ST_CHECA: begin
          if (bate) begin
            if (colisoes != '1) colisoes <= colisoes + 1'b1;
            vidas              <= vidas - 1'b1;
            posicao_horizontal <= h_ant;
            posicao_vertical   <= v_ant;
            if (vidas == WVID'(1)) begin
              perdeu <= 1'b1;
              estado <= ST_PERDEU;
            end else begin
              estado <= ST_ATUALIZA;
            end
          end else if (posicao_horizontal == H_MAX) begin
            venceu <= 1'b1;
            estado <= ST_VENCEU;
          end else begin
`ifdef DRONE_VIDA_EXTRA_EN
            if (!bonus_dado && posicao_horizontal >= H_MEIO) begin
              bonus_dado <= 1'b1;
              if (vidas != VID_INI) vidas <= vidas + 1'b1;
            end
`endif
            estado <= ST_ATUALIZA;
          end
        end
        ST_ATUALIZA: begin
          timer  <= '0;
          estado <= ST_ESPERA;
        end
        ST_VENCEU, ST_PERDEU: if (iniciar) estado <= ST_PREPARA;
        default: estado <= ST_INICIAL;
      endcase
    end
  end

endmodule
